// File: rtl/cpu_pkg.sv
// cpu_pkg: opcode/funct3 constants, redirect state enum and NOP shared by the branch unit
package cpu_pkg;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;
    localparam logic [31:0] NOP = 32'h0000_0013;
    typedef enum logic {RUN, SQUASH} state_e;
endpackage

// File: rtl/branch_redirect_if.sv
// branch_redirect_if: fetch/regfile inputs, fetch redirect and decode outputs; misalign exists with MISALIGN_TRAP_EN
interface branch_redirect_if;
    logic [31:0] instruction, PC, rs1_data, rs2_data;
    logic        npc_control;
    logic [31:0] branch_pc;
    logic        id_valid;
    logic [31:0] id_instruction, id_PC;
`ifdef MISALIGN_TRAP_EN
    logic        misalign;
    modport slave (input instruction, PC, rs1_data, rs2_data,
                   output npc_control, branch_pc, id_valid, id_instruction, id_PC, misalign);
    modport master (output instruction, PC, rs1_data, rs2_data,
                    input npc_control, branch_pc, id_valid, id_instruction, id_PC, misalign);
`else
    modport slave (input instruction, PC, rs1_data, rs2_data,
                   output npc_control, branch_pc, id_valid, id_instruction, id_PC);
    modport master (output instruction, PC, rs1_data, rs2_data,
                    input npc_control, branch_pc, id_valid, id_instruction, id_PC);
`endif
endinterface

// File: rtl/branch_cmp.sv
// branch_cmp: combinational RV32I jump/branch resolution (taken flag and target address)
module branch_cmp
    import cpu_pkg::*;
(
    input  logic [31:0] instruction,
    input  logic [31:0] PC,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    output logic        taken,
    output logic [31:0] target
);
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] imm_j, imm_i, imm_b;
    logic        eq, lt, ltu, cond;
    always_comb begin
        op    = instruction[6:0];
        f3    = instruction[14:12];
        imm_j = {{12{instruction[31]}}, instruction[19:12], instruction[20], instruction[30:21], 1'b0};
        imm_i = {{20{instruction[31]}}, instruction[31:20]};
        imm_b = {{20{instruction[31]}}, instruction[7], instruction[30:25], instruction[11:8], 1'b0};
        eq    = rs1_data == rs2_data;
        lt    = $signed(rs1_data) < $signed(rs2_data);
        ltu   = rs1_data < rs2_data;
        cond  = f3 == F3_BEQ  ? eq   :
                f3 == F3_BNE  ? !eq  :
                f3 == F3_BLT  ? lt   :
                f3 == F3_BGE  ? !lt  :
                f3 == F3_BLTU ? ltu  :
                f3 == F3_BGEU ? !ltu : 1'b0;
        taken  = op == OP_JAL || op == OP_JALR || (op == OP_BRANCH && cond);
        target = op == OP_JALR ? (rs1_data + imm_i) & ~32'h1 : PC + (op == OP_JAL ? imm_j : imm_b);
    end
endmodule

// File: rtl/branch_redirect.sv
// branch_redirect: registered fetch redirect plus wrong-path squash; MISALIGN_TRAP_EN traps misaligned targets
module branch_redirect
    import cpu_pkg::*;
#(
    parameter int          SQUASH_CYCLES = 1,
    parameter logic [31:0] TRAP_VECTOR   = 32'h0000_0100
)(
    input logic        clk,
    input logic        rst,
    branch_redirect_if.slave bus
);
    state_e      state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        npc_control_q, npc_control_d;
    logic [31:0] branch_pc_q, branch_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instruction_q, id_instruction_d;
    logic [31:0] id_PC_q, id_PC_d;
    logic        taken, run, go;
    logic [31:0] target, dest;

    branch_cmp u_cmp (
        .instruction(bus.instruction),
        .PC(bus.PC),
        .rs1_data(bus.rs1_data),
        .rs2_data(bus.rs2_data),
        .taken(taken),
        .target(target)
    );

    always_comb begin
        run              = state_q == RUN;
        go               = run && taken;
        state_d          = go ? SQUASH : (!run && cnt_q == 3'd1) ? RUN : state_q;
        cnt_d            = go ? 3'(SQUASH_CYCLES) : run ? cnt_q : cnt_q - 3'd1;
        npc_control_d    = go;
        branch_pc_d      = go ? dest : branch_pc_q;
        id_valid_d       = run;
        id_instruction_d = bus.instruction;
        id_PC_d          = bus.PC;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q          <= RUN;
            cnt_q            <= 3'd0;
            npc_control_q    <= 1'b0;
            branch_pc_q      <= 32'h0;
            id_valid_q       <= 1'b0;
            id_instruction_q <= NOP;
            id_PC_q          <= 32'h0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            npc_control_q    <= npc_control_d;
            branch_pc_q      <= branch_pc_d;
            id_valid_q       <= id_valid_d;
            id_instruction_q <= id_instruction_d;
            id_PC_q          <= id_PC_d;
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic misalign_q, misalign_d;
    always_comb begin
        misalign_d = go && target[1:0] != 2'b00;
        dest       = misalign_d ? TRAP_VECTOR : target;
    end
    always_ff @(posedge clk) misalign_q <= rst ? 1'b0 : misalign_d;
    assign bus.misalign = misalign_q;
`else
    assign dest = target;
`endif

    assign bus.npc_control    = npc_control_q;
    assign bus.branch_pc      = branch_pc_q;
    assign bus.id_valid       = id_valid_q;
    assign bus.id_instruction = id_instruction_q;
    assign bus.id_PC          = id_PC_q;
endmodule

// File: tb/tb_branch_redirect.sv
// tb_branch_redirect: two DUTs (squash depth 1 and 3) against an offset-level reference model
`timescale 1ns/1ps
module tb_branch_redirect;
    localparam logic [31:0] TRAP = 32'h0000_0100;
    logic        clk = 1'b0, rst = 1'b1;
    logic [31:0] instr = 32'h13, pc = 32'h0, r1 = 32'h0, r2 = 32'h0;
    int          tests = 0, fails = 0;
    bit          started = 1'b0;
    bit          m_tk = 1'b0;
    logic [31:0] m_tg = 32'h0;
    logic        e_npc [2], e_idv [2], e_mis [2];
    logic [31:0] e_bpc [2];
    logic [31:0] e_idi, e_idp;
    int          left [2];
    int          zeros, redirs;

    always #5 clk = ~clk;

    branch_redirect_if b0 (), b1 ();
    assign b0.instruction = instr;
    assign b0.PC          = pc;
    assign b0.rs1_data    = r1;
    assign b0.rs2_data    = r2;
    assign b1.instruction = instr;
    assign b1.PC          = pc;
    assign b1.rs1_data    = r1;
    assign b1.rs2_data    = r2;

    branch_redirect #(.SQUASH_CYCLES(1), .TRAP_VECTOR(TRAP)) d0 (.clk(clk), .rst(rst), .bus(b0));
    branch_redirect #(.SQUASH_CYCLES(3), .TRAP_VECTOR(TRAP)) d1 (.clk(clk), .rst(rst), .bus(b1));

    function automatic int depth(input int k);
        return k == 0 ? 1 : 3;
    endfunction

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%b expected=%b at %0t", n, act, exp, $time);
        end
    endtask

    // Model works from the intended offset/operands, never from the encoded bits.
    task automatic model_update();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                e_npc[k] = 1'b0; e_bpc[k] = 32'h0; e_idv[k] = 1'b0; e_mis[k] = 1'b0; left[k] = 0;
            end else if (left[k] > 0) begin
                e_npc[k] = 1'b0; e_idv[k] = 1'b0; e_mis[k] = 1'b0; left[k]--;
            end else begin
                e_idv[k] = 1'b1; e_npc[k] = m_tk; e_mis[k] = 1'b0;
                if (m_tk) begin
                    left[k] = depth(k);
`ifdef MISALIGN_TRAP_EN
                    e_mis[k] = m_tg[1:0] != 2'b00;
                    e_bpc[k] = e_mis[k] ? TRAP : m_tg;
`else
                    e_bpc[k] = m_tg;
`endif
                end
            end
        end
        e_idi = rst ? 32'h13 : instr;
        e_idp = rst ? 32'h0 : pc;
        started = 1'b1;
    endtask

    // kind: 0 raw instruction in imm, 1 JAL, 2 JALR, 3 BRANCH(f3)
    task automatic step(input int kind, input logic [2:0] f3, input logic [31:0] imm,
                        input logic [31:0] p, input logic [31:0] a, input logic [31:0] b);
        pc = p; r1 = a; r2 = b; m_tk = 1'b0; m_tg = 32'h0;
        case (kind)
            1: begin
                instr = {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'h6f};
                m_tk = 1'b1; m_tg = p + imm;
            end
            2: begin
                instr = {imm[11:0], 5'd2, 3'b000, 5'd1, 7'h67};
                m_tk = 1'b1; m_tg = (a + imm) & ~32'h1;
            end
            3: begin
                instr = {imm[12], imm[10:5], 5'd3, 5'd2, f3, imm[4:1], imm[11], 7'h63};
                m_tg = p + imm;
                case (f3)
                    3'd0: m_tk = a == b;
                    3'd1: m_tk = a != b;
                    3'd4: m_tk = $signed(a) < $signed(b);
                    3'd5: m_tk = $signed(a) >= $signed(b);
                    3'd6: m_tk = a < b;
                    3'd7: m_tk = a >= b;
                    default: m_tk = 1'b0;
                endcase
            end
            default: instr = imm;
        endcase
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic nop(input logic [31:0] p);
        step(0, 3'd0, 32'h0000_0013, p, 32'h0, 32'h0);
    endtask

    task automatic nops(input int n);
        for (int i = 0; i < n; i++) nop(32'h200 + 32'(i * 4));
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                chk1("npc0", b0.npc_control, e_npc[0]);
                chk ("bpc0", b0.branch_pc, e_bpc[0]);
                chk1("idv0", b0.id_valid, e_idv[0]);
                chk ("idi0", b0.id_instruction, e_idi);
                chk ("idp0", b0.id_PC, e_idp);
                chk1("npc1", b1.npc_control, e_npc[1]);
                chk ("bpc1", b1.branch_pc, e_bpc[1]);
                chk1("idv1", b1.id_valid, e_idv[1]);
                chk ("idi1", b1.id_instruction, e_idi);
                chk ("idp1", b1.id_PC, e_idp);
`ifdef MISALIGN_TRAP_EN
                chk1("mis0", b0.misalign, e_mis[0]);
                chk1("mis1", b1.misalign, e_mis[1]);
`endif
            end
        end
    end

    initial begin
        rst = 1'b1;
        nop(32'h0);
        nop(32'h0);
        chk ("rst_idi", b0.id_instruction, 32'h13);
        chk1("rst_idv", b0.id_valid, 1'b0);
        chk ("rst_bpc", b0.branch_pc, 32'h0);
        rst = 1'b0;
        step(1, 3'd0, 32'd16, 32'h20, 32'h0, 32'h0);
        chk1("jal_npc", b0.npc_control, 1'b1);
        chk ("jal_bpc", b0.branch_pc, 32'h30);
        chk1("jal_idv", b0.id_valid, 1'b1);
        step(0, 3'd0, 32'h0010_0093, 32'h24, 32'h0, 32'h0);
        chk1("jal_sq_idv", b0.id_valid, 1'b0);
        chk1("jal_sq_npc", b0.npc_control, 1'b0);
        chk ("jal_bpc_hold", b0.branch_pc, 32'h30);
        nop(32'h30);
        chk1("jal_run_idv", b0.id_valid, 1'b1);
        chk1("sq3_mid_idv", b1.id_valid, 1'b0);
        nop(32'h34);
        nop(32'h38);
        chk1("sq3_end_idv", b1.id_valid, 1'b1);
        step(3, 3'd0, -32'sd8, 32'h40, 32'd5, 32'd5);
        chk ("beq_bpc", b0.branch_pc, 32'h38);
        nops(3);
        step(3, 3'd0, -32'sd8, 32'h40, 32'd5, 32'd6);
        chk1("beq_nt_npc", b0.npc_control, 1'b0);
        nop(32'h44);
        chk1("beq_nt_idv", b1.id_valid, 1'b1);
        step(3, 3'd4, 32'd12, 32'h50, 32'hFFFF_FFFF, 32'd1);
        chk1("blt_npc", b0.npc_control, 1'b1);
        chk ("blt_bpc", b0.branch_pc, 32'h5C);
        nops(3);
        step(3, 3'd6, 32'd12, 32'h50, 32'hFFFF_FFFF, 32'd1);
        chk1("bltu_npc", b0.npc_control, 1'b0);
        step(3, 3'd1, 32'd32, 32'h60, 32'd1, 32'd2);
        nops(3);
        step(3, 3'd5, 32'd64, 32'h64, 32'd1, 32'hFFFF_FFFF);
        nops(3);
        step(3, 3'd7, 32'd64, 32'h68, 32'd1, 32'hFFFF_FFFF);
        step(3, 3'd2, 32'd64, 32'h6C, 32'd3, 32'd3);
        step(1, 3'd0, 32'd32, 32'hFFFF_FFF0, 32'h0, 32'h0);
        chk ("jal_wrap_bpc", b0.branch_pc, 32'h10);
        nops(3);
        step(2, 3'd0, 32'd0, 32'h70, 32'h101, 32'h0);
        chk ("jalr_bpc", b0.branch_pc, 32'h100);
        nops(3);
        step(2, 3'd0, 32'd1, 32'h74, 32'h101, 32'h0);
`ifdef MISALIGN_TRAP_EN
        chk ("jalr_trap_bpc", b0.branch_pc, TRAP);
        chk1("jalr_mis", b0.misalign, 1'b1);
        nop(32'h78);
        chk1("jalr_mis_end", b0.misalign, 1'b0);
        nops(2);
`else
        chk ("jalr_mis_bpc", b0.branch_pc, 32'h102);
        nops(3);
`endif
        step(3, 3'd0, 32'd8, 32'h80, 32'd7, 32'd7);
        chk1("sq3_br_npc", b1.npc_control, 1'b1);
        zeros = 0; redirs = 0;
        step(1, 3'd0, 32'd64, 32'h84, 32'h0, 32'h0);
        if (!b1.id_valid) zeros++;
        if (b1.npc_control) redirs++;
        for (int i = 0; i < 4; i++) begin
            nop(32'h88 + 32'(i * 4));
            if (!b1.id_valid) zeros++;
            if (b1.npc_control) redirs++;
        end
        chk ("sq3_count", 32'(zeros), 32'd3);
        chk ("sq3_jal_dropped", 32'(redirs), 32'd0);
        step(1, 3'd0, 32'd16, 32'hA0, 32'h0, 32'h0);
        nop(32'hA4);
        rst = 1'b1;
        nop(32'hB0);
        nop(32'hB4);
        chk ("rst_sq_idi", b1.id_instruction, 32'h13);
        chk1("rst_sq_idv", b1.id_valid, 1'b0);
        chk ("rst_sq_bpc", b1.branch_pc, 32'h0);
        rst = 1'b0;
        step(1, 3'd0, 32'd16, 32'hC0, 32'h0, 32'h0);
        chk1("rst_first_npc", b1.npc_control, 1'b1);
        chk ("rst_first_bpc", b1.branch_pc, 32'hD0);
        nops(4);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/branch_redirect.md
# branch_redirect

Resolves control flow for the instruction currently presented by the fetch stage and drives the fetch stage's redirect inputs (`npc_control`, `branch_pc`). It is the consumer end of the fetch interface: it takes `instruction`/`PC` from fetch plus operand data from the register file and evaluates RV32I branches and jumps. It issues a one-cycle registered redirect and squashes wrong-path instructions before they reach decode. It sits between the fetch stage and the decode stage.

## Interface

Parameters:
- `SQUASH_CYCLES`, default 1: number of wrong-path fetch cycles invalidated after a redirect; legal range 1–7.
- `TRAP_VECTOR`, default 32'h0000_0100: redirect target for a misaligned target. Used only when `MISALIGN_TRAP_EN` is defined.

Ports:
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `instruction` input 32: instruction from fetch.
- `PC` input 32: address of `instruction`.
- `rs1_data` input 32: register-file value for `instruction[19:15]`, valid in the same cycle.
- `rs2_data` input 32: register-file value for `instruction[24:20]`, valid in the same cycle.
- `npc_control` output 1: redirect request to fetch.
- `branch_pc` output 32: redirect target to fetch.
- `id_valid` output 1: decode-side instruction is valid (not squashed).
- `id_instruction` output 32: registered instruction to decode.
- `id_PC` output 32: registered PC to decode.
- `misalign` output 1: one-cycle pulse for a misaligned target. Present only when `MISALIGN_TRAP_EN` is defined.

## Operation

- Decode from `instruction[6:0]`:
  - JAL (7'b1101111): target = `PC` + imm_J.
  - JALR (7'b1100111): target = (`rs1_data` + imm_I) & ~32'h1.
  - BRANCH (7'b1100011): target = `PC` + imm_B; taken per funct3:
    - BEQ 000: equal.
    - BNE 001: not equal.
    - BLT 100: signed less-than.
    - BGE 101: signed greater-or-equal.
    - BLTU 110: unsigned less-than.
    - BGEU 111: unsigned greater-or-equal.
  - Funct3 010/011: never taken.
- Immediates are sign-extended to 32 bits. Additions are 32-bit modulo 2^32 (wrap-around, no flag).
- State machine with two states, RUN and SQUASH, plus a 3-bit squash counter.
  - RUN, taken jump/branch: register `npc_control`=1 and `branch_pc`=target; go to SQUASH with counter = `SQUASH_CYCLES`.
  - RUN, otherwise: `npc_control`=0.
  - SQUASH: input instruction is wrong-path. Its control flow is ignored (no redirect) and its `id_valid`=0. Decrement the counter each cycle; return to RUN when the counter reaches 1 and that cycle completes.
- Pipeline to decode: `id_instruction`/`id_PC` always capture the inputs. `id_valid` = 1 in RUN (including the taken branch itself, since JAL/JALR write rd) and 0 in SQUASH.
- `branch_pc` holds its last value when `npc_control`=0.

## Timing

- Reset values: `npc_control`=0, `branch_pc`=0, `id_valid`=0, `id_instruction`=32'h0000_0013 (NOP), `id_PC`=0, `misalign`=0; state RUN, counter 0.
- `rst` wins over every other event, including an in-flight SQUASH; the first instruction after reset is evaluated.
- Branch presented in cycle t: `npc_control` is high in cycle t+1 only. Fetch presents the target in cycle t+2.
- The instruction at PC+4 (present in cycle t+1) is squashed. With `SQUASH_CYCLES`=1, the target instruction is evaluated normally in cycle t+2.
- Decode latency is 1 cycle: inputs in cycle t appear on `id_*` in cycle t+1.
- Back-to-back taken branches: the second one falls inside SQUASH and is discarded.
- Not-taken branch: no redirect, no squash, `id_valid`=1.

## Configuration

- `MISALIGN_TRAP_EN` defined: a taken target with target[1:0]≠0 redirects to `TRAP_VECTOR` instead of the target, and pulses `misalign` for 1 cycle aligned with `npc_control`. Squash behaviour is unchanged.
- `MISALIGN_TRAP_EN` undefined: the target is issued unchanged and the `misalign` port does not exist.

## Structure

- Shared package `cpu_pkg`:
  - opcode constants (OP_JAL, OP_JALR, OP_BRANCH);
  - funct3 constants;
  - redirect state enum (RUN, SQUASH);
  - NOP constant 32'h0000_0013.
- Sub-module `branch_cmp` (combinational): takes instruction, PC, rs1_data, rs2_data; produces `taken` and `target`. The top level holds the FSM, counter and output registers.

## Test plan

- Reset asserted for 2 cycles mid-SQUASH → all outputs at reset values, `id_instruction`=32'h13, state RUN.
- JAL x1,+16 at PC 0x20 → next cycle `npc_control`=1, `branch_pc`=0x30, `id_valid`=1. Following cycle `id_valid`=0 (squash of 0x24). Then RUN.
- BEQ with rs1=rs2=5 at PC 0x40, offset −8 → `branch_pc`=0x38. Same with rs2=6 → no redirect, no squash.
- BLT with rs1=0xFFFF_FFFF, rs2=1 → taken. BLTU with the same operands → not taken.
- JALR with rs1=0x101, imm=0 → `branch_pc`=0x100. With `MISALIGN_TRAP_EN` and JALR target 0x102 → `branch_pc`=`TRAP_VECTOR`, `misalign` pulses 1 cycle.
- `SQUASH_CYCLES`=3, taken branch followed by a taken JAL in the next cycle → exactly 3 `id_valid`=0 cycles, and the JAL is not redirected.
